// File: rtl/rs_syndrome_stream.sv
// rs_syndrome_stream: streaming Reed-Solomon syndrome calculator with a one-deep output register
module rs_syndrome_stream #(
    parameter int                    SYMBOL_WIDTH = 8,
    parameter int                    N            = 18,
    parameter int                    K            = 16,
    parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 9'h11D,
    parameter int                    FCR          = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [SYMBOL_WIDTH-1:0]            in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [(N-K)*SYMBOL_WIDTH-1:0]      out_syn,
    output logic                               out_err,
    output logic                               out_len_err
);
    localparam int SW   = SYMBOL_WIDTH;
    localparam int NSYN = N - K;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] r;
        r = '0;
        for (int i = SW - 1; i >= 0; i--) begin
            r = {r[SW-2:0], 1'b0} ^ (r[SW-1] ? PRIM_POLY[SW-1:0] : '0);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] gf_pow(input int e);
        logic [SW-1:0] r;
        r = SW'(1);
        for (int i = 0; i < e; i++) r = gf_mul(r, SW'(2));
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NSYN*SW-1:0]   acc_q, acc_d, syn_nxt;
    logic [NSYN*SW-1:0]   syn_q, syn_d;
    logic                 err_q, err_d, len_err_q, len_err_d;
    logic                 accept, at_last_cnt, cw_end, first;

    assign accept      = in_valid && in_ready;
    assign at_last_cnt = (cnt_q == LAST_CNT);
    assign first       = (cnt_q == '0);
    assign cw_end      = accept && (in_last || at_last_cnt);
    assign in_ready    = !((at_last_cnt || in_last) && state_q == FULL && !out_ready);
    assign out_valid   = (state_q == FULL);
    assign out_syn     = syn_q;
    assign out_err     = err_q;
    assign out_len_err = len_err_q;

    // Horner step per syndrome; a counter of zero means the previous codeword is forgotten
    for (genvar j = 0; j < NSYN; j++) begin : g_syn
        localparam logic [SW-1:0] ROOT = gf_pow(FCR + j);
        assign syn_nxt[j*SW +: SW] = (first ? '0 : gf_mul(acc_q[j*SW +: SW], ROOT)) ^ in_data;
    end

    // Next-state for accumulators, symbol counter, output register and its EMPTY/FULL state
    always_comb begin
        acc_d     = accept ? syn_nxt : acc_q;
        cnt_d     = accept ? (cw_end ? '0 : cnt_q + CW'(1)) : cnt_q;
        syn_d     = cw_end ? syn_nxt : syn_q;
        err_d     = cw_end ? |syn_nxt : err_q;
        len_err_d = cw_end ? !(in_last && at_last_cnt) : len_err_q;
        state_d   = cw_end ? FULL : ((state_q == FULL && out_ready) ? EMPTY : state_q);
    end

    // Accumulator and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Output register and its occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            syn_q     <= '0;
            err_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            syn_q     <= syn_d;
            err_q     <= err_d;
            len_err_q <= len_err_d;
        end
    end
endmodule

// File: tb/tb_rs_syndrome_stream.sv
// tb_rs_syndrome_stream: directed self-checking bench for rs_syndrome_stream with default parameters
module tb_rs_syndrome_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_syn;
    logic        out_err;
    logic        out_len_err;
    int          chk = 0;
    int          fails = 0;

    rs_syndrome_stream dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_syn(out_syn), .out_err(out_err), .out_len_err(out_len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        while (!in_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk++; fails++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_word(input int n, input int pos, input logic [7:0] v, input logic last_at_end);
        for (int i = 0; i < n; i++) send((i == pos) ? v : 8'h00, (i == n - 1) && last_at_end);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        chk++; if (out_syn !== 16'h0000) begin fails++; $display("FAIL rst_syn: got %h want 0000", out_syn); end
        chk++; if (out_err !== 1'b0 || out_len_err !== 1'b0) begin fails++; $display("FAIL rst_flags: got %b%b want 00", out_err, out_len_err); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        send_word(17, -1, 8'h00, 1'b0);
        chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL zero_early_valid: got %b want 0", out_valid); end
        send(8'h00, 1'b1);
        chk++; if (out_valid !== 1'b1) begin fails++; $display("FAIL zero_valid: got %b want 1", out_valid); end
        chk++; if (out_syn !== 16'h0000) begin fails++; $display("FAIL zero_syn: got %h want 0000", out_syn); end
        chk++; if (out_err !== 1'b0 || out_len_err !== 1'b0) begin fails++; $display("FAIL zero_flags: got %b%b want 00", out_err, out_len_err); end
        idle();
        chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL zero_consumed: got %b want 0", out_valid); end
    endtask

    task automatic test_errors();
        send_word(18, 17, 8'h01, 1'b1);
        chk++; if (out_syn !== 16'h0101 || out_err !== 1'b1) begin fails++; $display("FAIL deg0: got %h err %b want 0101 err 1", out_syn, out_err); end
        idle();
        send_word(18, 16, 8'h01, 1'b1);
        chk++; if (out_syn !== 16'h0402 || out_err !== 1'b1 || out_len_err !== 1'b0) begin fails++; $display("FAIL deg1: got %h err %b len %b want 0402 1 0", out_syn, out_err, out_len_err); end
        idle();
        send_word(18, 0, 8'h01, 1'b1);
        chk++; if (out_syn !== 16'h4E98) begin fails++; $display("FAIL deg17: got %h want 4e98", out_syn); end
        idle();
    endtask

    task automatic test_len_err();
        send_word(5, 0, 8'h01, 1'b1);
        chk++; if (out_valid !== 1'b1 || out_len_err !== 1'b1) begin fails++; $display("FAIL short_len: valid %b len %b want 1 1", out_valid, out_len_err); end
        chk++; if (out_syn !== 16'h1D10 || out_err !== 1'b1) begin fails++; $display("FAIL short_syn: got %h err %b want 1d10 1", out_syn, out_err); end
        send_word(18, -1, 8'h00, 1'b1);
        chk++; if (out_len_err !== 1'b0 || out_syn !== 16'h0000) begin fails++; $display("FAIL restart: len %b syn %h want 0 0000", out_len_err, out_syn); end
        send_word(18, -1, 8'h00, 1'b0);
        chk++; if (out_valid !== 1'b1 || out_len_err !== 1'b1 || out_err !== 1'b0) begin fails++; $display("FAIL nolast: valid %b len %b err %b want 1 1 0", out_valid, out_len_err, out_err); end
        send(8'h01, 1'b1);
        chk++; if (out_syn !== 16'h0101 || out_len_err !== 1'b1) begin fails++; $display("FAIL after_nolast: syn %h len %b want 0101 1", out_syn, out_len_err); end
        send_word(18, -1, 8'h00, 1'b1);
        chk++; if (out_len_err !== 1'b0) begin fails++; $display("FAIL after_nolast_full: len %b want 0", out_len_err); end
        idle();
    endtask

    task automatic test_back_to_back();
        time t0;
        out_ready = 1'b1;
        t0 = $time;
        send_word(18, -1, 8'h00, 1'b1);
        chk++; if (out_valid !== 1'b1 || out_syn !== 16'h0000 || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_first: valid %b syn %h ready %b want 1 0000 1", out_valid, out_syn, in_ready); end
        send_word(18, 17, 8'h01, 1'b1);
        chk++; if (out_valid !== 1'b1 || out_syn !== 16'h0101) begin fails++; $display("FAIL b2b_second: valid %b syn %h want 1 0101", out_valid, out_syn); end
        send_word(18, 16, 8'h01, 1'b1);
        chk++; if (out_valid !== 1'b1 || out_syn !== 16'h0402) begin fails++; $display("FAIL b2b_third: valid %b syn %h want 1 0402", out_valid, out_syn); end
        chk++; if ($time - t0 !== 540) begin fails++; $display("FAIL b2b_rate: elapsed %0t want 540", $time - t0); end
        idle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_word(18, 16, 8'h01, 1'b1);
        chk++; if (out_valid !== 1'b1 || out_syn !== 16'h0402) begin fails++; $display("FAIL bp_a: valid %b syn %h want 1 0402", out_valid, out_syn); end
        send_word(17, -1, 8'h00, 1'b0);
        chk++; if (out_syn !== 16'h0402 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold: valid %b syn %h want 1 0402", out_valid, out_syn); end
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_last  = 1'b1;
        #1;
        chk++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall: in_ready %b want 0", in_ready); end
        idle();
        chk++; if (in_ready !== 1'b0 || out_syn !== 16'h0402) begin fails++; $display("FAIL bp_stall2: ready %b syn %h want 0 0402", in_ready, out_syn); end
        out_ready = 1'b1;
        #1;
        chk++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: in_ready %b want 1", in_ready); end
        idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk++; if (out_valid !== 1'b1 || out_syn !== 16'h0101 || out_err !== 1'b1 || out_len_err !== 1'b0) begin fails++; $display("FAIL bp_b: valid %b syn %h err %b len %b want 1 0101 1 0", out_valid, out_syn, out_err, out_len_err); end
        idle();
        chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: valid %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_word(18, 17, 8'h01, 1'b1);
        for (int i = 0; i < 9; i++) send(8'h55, 1'b0);
        chk++; if (out_valid !== 1'b1 || out_syn !== 16'h0101) begin fails++; $display("FAIL rm_held: valid %b syn %h want 1 0101", out_valid, out_syn); end
        #2;
        rst_n = 1'b0;
        #1;
        chk++; if (out_valid !== 1'b0 || out_syn !== 16'h0000 || out_err !== 1'b0 || out_len_err !== 1'b0) begin fails++; $display("FAIL rm_async: valid %b syn %h err %b len %b want 0 0000 0 0", out_valid, out_syn, out_err, out_len_err); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle();
        send_word(17, -1, 8'h00, 1'b0);
        chk++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_stale: valid %b want 0", out_valid); end
        send(8'h00, 1'b1);
        chk++; if (out_valid !== 1'b1 || out_syn !== 16'h0000 || out_len_err !== 1'b0 || out_err !== 1'b0) begin fails++; $display("FAIL rm_clean: valid %b syn %h len %b err %b want 1 0000 0 0", out_valid, out_syn, out_len_err, out_err); end
        idle();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_errors();
        test_len_err();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
        $finish;
    end
endmodule
